// File: rtl/noc_vc_switch_arbiter_pkg.sv
// Shared constants and types for the input-port switch-allocation stage.
// Flit type bits are addressed as offsets from the flit MSB so any FLIT_W works.
package noc_vc_switch_arbiter_pkg;

    localparam int HEAD_BIT_OFS = 1;  // HEAD lives at FLIT_W-1
    localparam int TAIL_BIT_OFS = 2;  // TAIL lives at FLIT_W-2

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    function automatic int vc_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/noc_vc_switch_arbiter_rr_arbiter.sv
// Combinational round-robin priority picker: the search starts one past ptr and
// wraps modulo CHANNELS; the first requester found wins.
module noc_rr_arbiter #(
    parameter int CHANNELS = 32,
    parameter int VC_W     = 5
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [VC_W-1:0]     ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [VC_W-1:0]     idx,
    output logic                any
);

    logic [VC_W-1:0] cand;

    // NOTE: every variable assigned in a combinational block gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 1; off <= CHANNELS; off++) begin
            cand = VC_W'((int'(ptr) + off) % CHANNELS);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/noc_vc_switch_arbiter.sv
// Per-input-port switch allocator: picks one VC flit per cycle round-robin,
// holds the port for a VC until its tail passes (wormhole), registers the winner.
module noc_vc_switch_arbiter
    import noc_vc_switch_arbiter_pkg::*;
#(
    parameter int CHANNELS = 32,
    parameter int FLIT_W   = 64,
    parameter int VC_W     = vc_width(CHANNELS)
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic [CHANNELS-1:0]        i_valid,
    input  logic [CHANNELS*FLIT_W-1:0] i_flit,
    output logic [CHANNELS-1:0]        i_ready,
    output logic                       o_valid,
    output logic [FLIT_W-1:0]          o_flit,
    output logic [VC_W-1:0]            o_vc,
    input  logic                       o_ready,
    output logic                       o_err
);

    arb_state_t          state_q, state_d;
    logic [VC_W-1:0]     lock_vc_q, lock_vc_d;
    logic [VC_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [FLIT_W-1:0]   flit_arr [CHANNELS];
    logic [CHANNELS-1:0] head_vec, tail_vec;
    logic [CHANNELS-1:0] lock_mask, req, grant;
    logic [VC_W-1:0]     win;
    logic                win_any, win_tail;
    logic [FLIT_W-1:0]   win_flit;
    logic                load, fire, err_set;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
        assign flit_arr[c] = i_flit[c*FLIT_W +: FLIT_W];
        assign head_vec[c] = flit_arr[c][FLIT_W-HEAD_BIT_OFS];
        assign tail_vec[c] = flit_arr[c][FLIT_W-TAIL_BIT_OFS];
    end

    // While locked only the owning VC may compete, whatever its flit type.
    assign lock_mask = CHANNELS'(1) << lock_vc_q;
    assign req       = (state_q == ARB_IDLE) ? (i_valid & head_vec) : (i_valid & lock_mask);

    noc_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .VC_W     (VC_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (win),
        .any   (win_any)
    );

    assign win_flit = flit_arr[win];
    assign win_tail = tail_vec[win];
    assign err_set  = (state_q == ARB_IDLE) && |(i_valid & ~head_vec);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q   <= ARB_IDLE;
            lock_vc_q <= '0;
            rr_ptr_q  <= VC_W'(CHANNELS - 1);
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (fire) begin
                    rr_ptr_d = win;
                    if (!win_tail) begin
                        state_d   = ARB_LOCKED;
                        lock_vc_d = win;
                    end
                end
            end
            ARB_LOCKED: begin
                if (fire && win_tail) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Pops are suppressed during reset so the upstream FIFOs see no stray grant.
    always_comb begin
        load    = !o_valid || o_ready;
        fire    = load && win_any;
        i_ready = '0;
        if (fire && noc_rst_n) begin
            i_ready = grant;
        end
    end

    // NOTE: the flit register is reset along with its valid bit so o_flit/o_vc
    // read as zero after reset rather than carrying stale packet data.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            o_valid <= 1'b0;
            o_flit  <= '0;
            o_vc    <= '0;
        end else if (load) begin
            o_valid <= fire;
            if (fire) begin
                o_flit <= win_flit;
                o_vc   <= win;
            end
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            o_err <= 1'b0;
        end else if (err_set) begin
            o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_vc_switch_arbiter.sv
// Scenario bench for noc_vc_switch_arbiter (CHANNELS=4, FLIT_W=16): directed
// wormhole/fairness/stall/error/reset cases plus random traffic vs a reference model.
module tb_noc_vc_switch_arbiter;

    localparam int CH = 4;
    localparam int FW = 16;
    localparam int VW = 2;

    logic               noc_clk;
    logic               noc_rst_n;
    logic [CH-1:0]      i_valid;
    logic [CH*FW-1:0]   i_flit;
    logic [CH-1:0]      i_ready;
    logic               o_valid;
    logic [FW-1:0]      o_flit;
    logic [VW-1:0]      o_vc;
    logic               o_ready;
    logic               o_err;

    int n_checks = 0;
    int n_errors = 0;

    // Upstream per-VC FIFOs, popped whenever the DUT raises i_ready.
    logic [FW-1:0] q [CH][$];

    noc_vc_switch_arbiter #(
        .CHANNELS (CH),
        .FLIT_W   (FW),
        .VC_W     (VW)
    ) dut (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .i_valid   (i_valid),
        .i_flit    (i_flit),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_flit    (o_flit),
        .o_vc      (o_vc),
        .o_ready   (o_ready),
        .o_err     (o_err)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    // Flit layout: {HEAD, TAIL, vc[1:0], seq[11:0]}
    function automatic logic [FW-1:0] mk(input bit h, input bit t, input int vc, input int seq);
        return {h, t, 2'(vc), 12'(seq)};
    endfunction

    task automatic drive(input logic [CH-1:0] mask);
        for (int c = 0; c < CH; c++) begin
            if (q[c].size() > 0) begin
                i_valid[c]          = mask[c];
                i_flit[c*FW +: FW]  = q[c][0];
            end else begin
                i_valid[c]          = 1'b0;
                i_flit[c*FW +: FW]  = 16'($urandom);
            end
        end
        #1;
    endtask

    task automatic tick();
        logic [CH-1:0] rdy;
        logic [FW-1:0] tmp;
        rdy = i_ready;
        @(posedge noc_clk);
        for (int c = 0; c < CH; c++) begin
            if (rdy[c] && q[c].size() > 0) tmp = q[c].pop_front();
        end
        @(negedge noc_clk);
    endtask

    task automatic apply_reset();
        for (int c = 0; c < CH; c++) q[c].delete();
        o_ready   = 1'b1;
        noc_rst_n = 1'b0;
        i_valid   = '0;
        i_flit    = '0;
        repeat (2) @(negedge noc_clk);
        noc_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        noc_rst_n = 1'b0;
        o_ready   = 1'b1;
        q[0].push_back(mk(1, 1, 0, 0));
        q[2].push_back(mk(1, 1, 2, 0));
        @(negedge noc_clk);
        drive(4'hF);
        n_checks++; if (i_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_ready got %b want 0000", i_ready); end
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
        n_checks++; if (o_flit !== 16'h0) begin n_errors++; $display("FAIL rst_flit got %h want 0000", o_flit); end
        n_checks++; if (o_vc !== 2'd0) begin n_errors++; $display("FAIL rst_vc got %0d want 0", o_vc); end
        n_checks++; if (o_err !== 1'b0) begin n_errors++; $display("FAIL rst_err got %b want 0", o_err); end
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        drive(4'hF);
        n_checks++; if (i_ready !== 4'b0001) begin n_errors++; $display("FAIL rst_first_grant got %b want 0001", i_ready); end
        tick();
        drive(4'hF);
        tick();
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int v = 0; v < CH; v++)
            for (int s = 0; s < 3; s++) q[v].push_back(mk(1, 1, v, s));
        for (int k = 0; k <= 12; k++) begin
            drive(4'hF);
            if (k < 12) begin
                n_checks++; if (i_ready !== 4'(1 << (k % 4))) begin n_errors++; $display("FAIL fair_grant k=%0d got %b want %b", k, i_ready, 4'(1 << (k % 4))); end
            end else begin
                n_checks++; if (i_ready !== 4'b0000) begin n_errors++; $display("FAIL fair_idle got %b want 0000", i_ready); end
            end
            if (k > 0) begin
                n_checks++; if (o_valid !== 1'b1 || o_vc !== 2'((k - 1) % 4) || o_flit !== mk(1, 1, (k - 1) % 4, (k - 1) / 4))
                    begin n_errors++; $display("FAIL fair_out k=%0d got v=%b vc=%0d f=%h want vc=%0d f=%h", k, o_valid, o_vc, o_flit, (k - 1) % 4, mk(1, 1, (k - 1) % 4, (k - 1) / 4)); end
            end
            tick();
        end
        drive(4'hF);
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL fair_drain got %b want 0", o_valid); end
    endtask

    task automatic test_wormhole();
        int g [5] = '{1, 1, 1, 1, 2};
        logic [FW-1:0] ef [5];
        apply_reset();
        ef[0] = mk(1, 0, 1, 0); ef[1] = mk(0, 0, 1, 1); ef[2] = mk(0, 0, 1, 2); ef[3] = mk(0, 1, 1, 3);
        ef[4] = mk(1, 1, 2, 0);
        for (int i = 0; i < 4; i++) q[1].push_back(ef[i]);
        q[2].push_back(ef[4]);
        for (int k = 0; k <= 5; k++) begin
            drive(4'hF);
            if (k < 5) begin
                n_checks++; if (i_ready !== 4'(1 << g[k])) begin n_errors++; $display("FAIL worm_grant k=%0d got %b want %b", k, i_ready, 4'(1 << g[k])); end
            end
            if (k > 0) begin
                n_checks++; if (o_valid !== 1'b1 || o_vc !== 2'(g[k-1]) || o_flit !== ef[k-1])
                    begin n_errors++; $display("FAIL worm_out k=%0d got v=%b vc=%0d f=%h want vc=%0d f=%h", k, o_valid, o_vc, o_flit, g[k-1], ef[k-1]); end
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        apply_reset();
        q[1].push_back(mk(1, 0, 1, 0));
        q[1].push_back(mk(0, 0, 1, 1));
        for (int k = 0; k < 2; k++) begin
            drive(4'hF);
            n_checks++; if (i_ready !== 4'b0010) begin n_errors++; $display("FAIL starve_lock k=%0d got %b want 0010", k, i_ready); end
            tick();
        end
        q[0].push_back(mk(1, 1, 0, 0));
        for (int k = 2; k < 5; k++) begin
            drive(4'hF);
            n_checks++; if (i_ready !== 4'b0000) begin n_errors++; $display("FAIL starve_block k=%0d got %b want 0000", k, i_ready); end
            n_checks++; if (o_valid !== (k == 2)) begin n_errors++; $display("FAIL starve_valid k=%0d got %b want %b", k, o_valid, k == 2); end
            tick();
        end
        q[1].push_back(mk(0, 1, 1, 2));
        drive(4'hF);
        n_checks++; if (i_ready !== 4'b0010 || o_valid !== 1'b0) begin n_errors++; $display("FAIL starve_resume got r=%b v=%b want r=0010 v=0", i_ready, o_valid); end
        tick();
        drive(4'hF);
        n_checks++; if (o_valid !== 1'b1 || o_vc !== 2'd1 || o_flit !== mk(0, 1, 1, 2)) begin n_errors++; $display("FAIL starve_tail got v=%b vc=%0d f=%h want vc=1 f=%h", o_valid, o_vc, o_flit, mk(0, 1, 1, 2)); end
        n_checks++; if (i_ready !== 4'b0001) begin n_errors++; $display("FAIL starve_release got %b want 0001", i_ready); end
        tick();
        drive(4'hF);
        n_checks++; if (o_valid !== 1'b1 || o_vc !== 2'd0) begin n_errors++; $display("FAIL starve_vc0 got v=%b vc=%0d want vc=0", o_valid, o_vc); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] eo [3];
        logic [CH-1:0] er [3];
        apply_reset();
        q[0].push_back(mk(1, 1, 0, 0));
        q[0].push_back(mk(1, 1, 0, 1));
        q[2].push_back(mk(1, 1, 2, 0));
        q[3].push_back(mk(1, 1, 3, 0));
        eo[0] = mk(1, 1, 2, 0); eo[1] = mk(1, 1, 3, 0); eo[2] = mk(1, 1, 0, 1);
        er[0] = 4'b1000;        er[1] = 4'b0001;        er[2] = 4'b0000;
        o_ready = 1'b1;
        drive(4'hF);
        n_checks++; if (i_ready !== 4'b0001) begin n_errors++; $display("FAIL bp_first got %b want 0001", i_ready); end
        tick();
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(4'hF);
            n_checks++; if (i_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready k=%0d got %b want 0000", k, i_ready); end
            n_checks++; if (o_valid !== 1'b1 || o_vc !== 2'd0 || o_flit !== mk(1, 1, 0, 0))
                begin n_errors++; $display("FAIL bp_hold k=%0d got v=%b vc=%0d f=%h want vc=0 f=%h", k, o_valid, o_vc, o_flit, mk(1, 1, 0, 0)); end
            tick();
        end
        o_ready = 1'b1;
        drive(4'hF);
        n_checks++; if (i_ready !== 4'b0100) begin n_errors++; $display("FAIL bp_release got %b want 0100", i_ready); end
        tick();
        for (int j = 0; j < 3; j++) begin
            drive(4'hF);
            n_checks++; if (o_valid !== 1'b1 || o_flit !== eo[j]) begin n_errors++; $display("FAIL bp_order j=%0d got v=%b f=%h want %h", j, o_valid, o_flit, eo[j]); end
            n_checks++; if (i_ready !== er[j]) begin n_errors++; $display("FAIL bp_grant j=%0d got %b want %b", j, i_ready, er[j]); end
            tick();
        end
        drive(4'hF);
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain got %b want 0", o_valid); end
    endtask

    task automatic test_protocol_error();
        apply_reset();
        q[3].push_back(mk(0, 0, 3, 0));
        q[0].push_back(mk(1, 1, 0, 0));
        drive(4'hF);
        n_checks++; if (o_err !== 1'b0) begin n_errors++; $display("FAIL err_early got %b want 0", o_err); end
        n_checks++; if (i_ready !== 4'b0001) begin n_errors++; $display("FAIL err_vc0 got %b want 0001", i_ready); end
        tick();
        for (int k = 1; k < 5; k++) begin
            drive(4'hF);
            n_checks++; if (o_err !== 1'b1) begin n_errors++; $display("FAIL err_set k=%0d got %b want 1", k, o_err); end
            n_checks++; if (i_ready !== 4'b0000) begin n_errors++; $display("FAIL err_nogrant k=%0d got %b want 0000", k, i_ready); end
            if (k == 1) begin
                n_checks++; if (o_valid !== 1'b1 || o_vc !== 2'd0) begin n_errors++; $display("FAIL err_fwd got v=%b vc=%0d want vc=0", o_valid, o_vc); end
            end
            tick();
        end
        q[3].delete();
        drive(4'hF);
        n_checks++; if (o_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b want 1", o_err); end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        q[1].push_back(mk(1, 0, 1, 0));
        q[1].push_back(mk(0, 0, 1, 1));
        q[1].push_back(mk(0, 0, 1, 2));
        q[1].push_back(mk(0, 1, 1, 3));
        q[3].push_back(mk(0, 0, 3, 0));
        drive(4'hF); tick();
        drive(4'hF); tick();
        drive(4'hF);
        n_checks++; if (o_valid !== 1'b1 || o_err !== 1'b1) begin n_errors++; $display("FAIL mid_pre got v=%b e=%b want v=1 e=1", o_valid, o_err); end
        #2 noc_rst_n = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b0 || o_err !== 1'b0) begin n_errors++; $display("FAIL mid_async got v=%b e=%b want 0 0", o_valid, o_err); end
        n_checks++; if (o_flit !== 16'h0 || o_vc !== 2'd0 || i_ready !== 4'b0000)
            begin n_errors++; $display("FAIL mid_clear got f=%h vc=%0d r=%b want 0", o_flit, o_vc, i_ready); end
        for (int c = 0; c < CH; c++) q[c].delete();
        q[2].push_back(mk(1, 1, 2, 0));
        q[3].push_back(mk(1, 1, 3, 0));
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        drive(4'hF);
        n_checks++; if (i_ready !== 4'b0100) begin n_errors++; $display("FAIL mid_first got %b want 0100", i_ready); end
        tick();
        drive(4'hF);
        n_checks++; if (o_valid !== 1'b1 || o_vc !== 2'd2 || o_err !== 1'b0) begin n_errors++; $display("FAIL mid_after got v=%b vc=%0d e=%b want v=1 vc=2 e=0", o_valid, o_vc, o_err); end
        tick();
        drive(4'hF);
        tick();
    endtask

    // Random packets, random upstream gaps and random crossbar stalls checked
    // cycle by cycle against a rule-level model of the arbiter.
    task automatic test_random_traffic();
        int m_lock, m_ptr, m_ovc, win, cyc, seq, len;
        bit m_ov, m_err, load, bad, busy;
        logic [FW-1:0] m_of, wf;
        logic [CH-1:0] exp_ready;
        apply_reset();
        for (int v = 0; v < CH; v++) begin
            seq = 0;
            for (int p = 0; p < 4; p++) begin
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    q[v].push_back(mk(i == 0, i == len - 1, v, seq));
                    seq++;
                end
            end
        end
        m_lock = -1; m_ptr = CH - 1; m_ov = 0; m_of = '0; m_ovc = 0; m_err = 0;
        cyc = 0;
        busy = 1;
        while (busy && cyc < 2000) begin
            o_ready = ($urandom_range(0, 3) != 0);
            drive(4'($urandom));
            load = !m_ov || o_ready;
            win  = -1;
            bad  = 0;
            wf   = '0;
            if (m_lock >= 0) begin
                if (i_valid[m_lock]) win = m_lock;
            end else begin
                for (int k = 1; k <= CH; k++) begin
                    int c;
                    c = (m_ptr + k) % CH;
                    if (win < 0 && i_valid[c] && q[c][0][FW-1]) win = c;
                end
                for (int c = 0; c < CH; c++) if (i_valid[c] && !q[c][0][FW-1]) bad = 1;
            end
            if (win >= 0) wf = q[win][0];
            exp_ready = (load && win >= 0) ? 4'(1 << win) : 4'b0000;
            n_checks++; if (i_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, i_ready, exp_ready); end
            n_checks++; if (o_valid !== m_ov) begin n_errors++; $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, o_valid, m_ov); end
            if (m_ov) begin
                n_checks++; if (o_flit !== m_of || o_vc !== 2'(m_ovc)) begin n_errors++; $display("FAIL rnd_out cyc=%0d got f=%h vc=%0d want f=%h vc=%0d", cyc, o_flit, o_vc, m_of, m_ovc); end
            end
            n_checks++; if (o_err !== m_err) begin n_errors++; $display("FAIL rnd_err cyc=%0d got %b want %b", cyc, o_err, m_err); end
            if (load) begin
                m_ov = (win >= 0);
                if (win >= 0) begin
                    m_of  = wf;
                    m_ovc = win;
                    if (m_lock < 0) begin
                        m_ptr = win;
                        if (!wf[FW-2]) m_lock = win;
                    end else if (wf[FW-2]) begin
                        m_lock = -1;
                    end
                end
            end
            if (bad) m_err = 1;
            tick();
            cyc++;
            busy = m_ov;
            for (int c = 0; c < CH; c++) if (q[c].size() > 0) busy = 1;
        end
        n_checks++; if (busy) begin n_errors++; $display("FAIL rnd_timeout got busy after %0d cycles want drained", cyc); end
    endtask

    initial begin
        noc_rst_n = 1'b0;
        o_ready   = 1'b1;
        i_valid   = '0;
        i_flit    = '0;
        test_reset();
        test_fairness();
        test_wormhole();
        test_starvation();
        test_backpressure();
        test_protocol_error();
        test_reset_mid_packet();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
